divider: RTL
============

DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: XLEN, default 64, operand/result width; only 64 is supported.
REQ-002 One clock; reset is asynchronous and active-low: clk, rst_n.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start_valid  in  1  request present.
REQ-006 start_ready  out  1  unit can accept a request.
REQ-007 op  in  2  operation: 0 DIV, 1 DIVU, 2 REM, 3 REMU.
REQ-008 word  in  1  32-bit W-variant select; exists only with DIV_WORD_OPS_EN.
REQ-009 rs1_data  in  XLEN  dividend, taken from the register file read port.
REQ-010 rs2_data  in  XLEN  divisor, taken from the register file read port.
REQ-011 rd_addr_in  in  5  destination register tag.
REQ-012 kill  in  1  abort the in-flight operation.
REQ-013 result_valid  out  1  result available.
REQ-014 result_ready  in  1  consumer accepts the result; register file write_enable = result_valid & result_ready.
REQ-015 result  out  XLEN  quotient or remainder.
REQ-016 rd_addr_out  out  5  captured rd_addr_in.

Function
REQ-017 States: IDLE, CALC, DONE.
REQ-018 start_ready is 1 only in IDLE.
REQ-019 In IDLE, start_valid=1 latches op, operands and rd_addr_in.
REQ-020 The unit leaves IDLE on that accept edge.
REQ-021 Divide by zero goes directly to DONE.
REQ-022 Signed overflow (most-negative / -1) goes directly to DONE.
REQ-023 All other requests go to CALC.
REQ-024 CALC runs radix-2 restoring division on operand magnitudes.
REQ-025 CALC performs one quotient bit per cycle for exactly XLEN cycles, then goes to DONE.
REQ-026 Sign fix-up is applied on entry to DONE.
REQ-027 Quotient sign = sign(rs1) XOR sign(rs2).
REQ-028 Remainder sign = sign(rs1).
REQ-029 Latency from the accept edge to result_valid=1: 1 cycle for special cases, XLEN+1 cycles otherwise.
REQ-030 Divide by zero: quotient all ones; remainder = dividend.
REQ-031 Signed overflow: quotient = dividend; remainder = 0.
REQ-032 In DONE, result_valid=1 and result/rd_addr_out stay stable until result_ready=1.
REQ-033 DONE with result_ready=1 returns to IDLE on the next edge.
REQ-034 No request is accepted in the same cycle as result handoff.
REQ-035 kill=1 in any state forces IDLE on the next edge and discards the operation.
REQ-036 kill has priority over result_ready and start_valid.
REQ-037 In IDLE, kill=1 together with start_valid=1 rejects the request.
REQ-038 rd_addr_out is passed through unmodified; rd=0 is not filtered here.

Reset
REQ-039 rst_n=0 asynchronously forces IDLE.
REQ-040 Under reset: start_ready=1, result_valid=0, result=0, rd_addr_out=0, iteration counter=0.
REQ-041 Reset asserted mid-CALC discards the operation; no result_valid pulse follows.

Configuration
REQ-042 Macro DIV_WORD_OPS_EN controls the W variants.
REQ-043 With DIV_WORD_OPS_EN defined, word=1 gives DIVW/DIVUW/REMW/REMUW.
REQ-044 Word-op inputs: operands are sign- or zero-extended from bits [31:0] per op, and CALC runs 32 cycles.
REQ-045 Word-op output: the 32-bit result is sign-extended to XLEN for all four ops.
REQ-046 Word-op special cases: divide by zero returns all ones; overflow returns 0xFFFFFFFF80000000.
REQ-047 Without DIV_WORD_OPS_EN, the word port and its logic are absent and latency is always XLEN+1.

Structure
REQ-048 Package div_pkg holds: XLEN constant, op enum, state enum, special-case result constants.
REQ-049 One sub-module, div_step, holds the combinational restoring iteration (shift, trial subtract, quotient bit).

Verification
REQ-050 DIVU 100/7 -> result 14 at cycle 65 after accept; REMU 100/7 -> 2.
REQ-051 DIV -7/2 -> 0xFFFFFFFFFFFFFFFD; REM -7/2 -> 0xFFFFFFFFFFFFFFFF.
REQ-052 DIV 5/0 -> 0xFFFFFFFFFFFFFFFF one cycle after accept; REM 5/0 -> 5.
REQ-053 DIV 0x8000000000000000/-1 -> 0x8000000000000000 one cycle after accept; REM -> 0.
REQ-054 result_ready held 0 for 10 cycles in DONE -> result and rd_addr_out stable, start_ready=0.
REQ-054 (cont.) On release -> start_ready=1 next cycle.
REQ-055 kill at CALC cycle 20 -> IDLE next edge, no result_valid.
REQ-056 rst_n low at CALC cycle 30 -> immediate IDLE outputs, no result_valid.
REQ-057 With DIV_WORD_OPS_EN, DIVUW 0xFFFFFFFF/1 -> 0xFFFFFFFFFFFFFFFF after 33 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared divider types: operand width, op/state encodings, special-case constants.
// Optional W-variant support in the divider is controlled by DIV_WORD_OPS_EN.
package div_pkg;
    localparam int DIV_XLEN  = 64;
    localparam int DIV_CNT_W = $clog2(DIV_XLEN) + 1;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam logic [DIV_XLEN-1:0] DIV_ZERO_QUO = '1;
    localparam logic [DIV_XLEN-1:0] OVF_REM      = '0;
    localparam logic [DIV_XLEN-1:0] MOST_NEG     = {1'b1, {(DIV_XLEN-1){1'b0}}};
    localparam logic [DIV_XLEN-1:0] MOST_NEG_W   = {{(DIV_XLEN-31){1'b1}}, 31'b0};

    function automatic logic [DIV_XLEN-1:0] sext_w(input logic [DIV_XLEN-1:0] x);
        return {{(DIV_XLEN-32){x[31]}}, x[31:0]};
    endfunction
endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift, trial subtract, quotient bit.
// Purely combinational; the caller holds partial remainder and dividend/quotient.
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_XLEN
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);
    logic [W:0] shifted;
    logic [W:0] diff;
    logic       qbit;

    // Partial remainder stays below the divisor, so the trial result fits in W bits.
    assign shifted = {rem_i, quo_i[W-1]};
    assign diff    = shifted - {1'b0, dvs_i};
    assign qbit    = ~diff[W];
    assign rem_o   = qbit ? diff[W-1:0] : shifted[W-1:0];
    assign quo_o   = {quo_i[W-2:0], qbit};
endmodule

// File: rtl/divider.sv
// Iterative signed/unsigned divider with valid/ready handshake, kill, and optional
// 32-bit W variants (DIV_WORD_OPS_EN). Latency 1 cycle for special cases, else XLEN+1.
module divider
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [1:0]      op,
`ifdef DIV_WORD_OPS_EN
    input  logic            word,
`endif
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr_in,
    input  logic            kill,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr_out
);
    div_state_e             state_q, state_d;
    logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]        rem_q, rem_d;
    logic [XLEN-1:0]        quo_q, quo_d;
    logic [XLEN-1:0]        dvs_q, dvs_d;
    logic                   is_rem_q, is_rem_d;
    logic                   q_neg_q, q_neg_d;
    logic                   r_neg_q, r_neg_d;
    logic [XLEN-1:0]        result_q, result_d;
    logic [4:0]             rd_q, rd_d;
    logic                   word_in, word_q;

    div_op_e         op_in;
    logic            is_signed, is_rem, accept;
    logic [XLEN-1:0] a_in, b_in, a_mag, b_mag;
    logic            a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0] step_rem, step_quo, quo_fix, rem_fix;
    logic [DIV_CNT_W-1:0] last_cnt;

    assign op_in     = div_op_e'(op);
    assign is_signed = (op_in == OP_DIV) || (op_in == OP_REM);
    assign is_rem    = (op_in == OP_REM) || (op_in == OP_REMU);
    assign accept    = (state_q == ST_IDLE) && start_valid && !kill;

`ifdef DIV_WORD_OPS_EN
    assign word_in = word;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      word_q <= 1'b0;
        else if (accept) word_q <= word;
    end
`else
    assign word_in = 1'b0;
    assign word_q  = 1'b0;
`endif

    always_comb begin
        a_in = rs1_data;
        b_in = rs2_data;
        if (word_in) begin
            a_in = is_signed ? sext_w(rs1_data) : {{(XLEN-32){1'b0}}, rs1_data[31:0]};
            b_in = is_signed ? sext_w(rs2_data) : {{(XLEN-32){1'b0}}, rs2_data[31:0]};
        end
    end

    assign a_neg    = is_signed && a_in[XLEN-1];
    assign b_neg    = is_signed && b_in[XLEN-1];
    assign a_mag    = a_neg ? -a_in : a_in;
    assign b_mag    = b_neg ? -b_in : b_in;
    assign div_zero = (b_in == '0);
    assign ovf      = is_signed && (b_in == '1) && (a_in == (word_in ? MOST_NEG_W : MOST_NEG));

    div_step #(.W(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign quo_fix  = q_neg_q ? -step_quo : step_quo;
    assign rem_fix  = r_neg_q ? -step_rem : step_rem;
    assign last_cnt = word_q ? DIV_CNT_W'(31) : DIV_CNT_W'(XLEN-1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        rd_d     = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rd_d     = rd_addr_in;
                    is_rem_d = is_rem;
                    q_neg_d  = a_neg ^ b_neg;
                    r_neg_d  = a_neg;
                    cnt_d    = '0;
                    rem_d    = '0;
                    // Word dividends sit in the upper half so 32 shifts consume them.
                    quo_d    = word_in ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
                    dvs_d    = b_mag;
                    if (div_zero) begin
                        result_d = is_rem ? a_in : DIV_ZERO_QUO;
                        if (word_in) result_d = sext_w(result_d);
                        state_d  = ST_DONE;
                    end else if (ovf) begin
                        result_d = is_rem ? OVF_REM : a_in;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + DIV_CNT_W'(1);
                if (cnt_q == last_cnt) begin
                    result_d = is_rem_q ? rem_fix : quo_fix;
                    if (word_q) result_d = sext_w(result_d);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (kill) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign start_ready  = (state_q == ST_IDLE);
    assign result_valid = (state_q == ST_DONE);
    assign result       = result_q;
    assign rd_addr_out  = rd_q;
endmodule
